// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences an external combinational MAC (DATA_W x DATA_W
// multiply plus ACC_W accumulate) through an N-element dot product.
// Operand pairs arrive over a valid/ready handshake. The running sum lives
// in r_acc and is fed back to the MAC as its accumulator input. The final
// sum is reported with a one-cycle done pulse.
// Optional build macro: MAC_SEQ_OVF_EN enables the sticky wrap flag (ovf).
// Without it, ovf is tied low.
module mac_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic [ACC_W-1:0]  mac_acc,
    input  logic [ACC_W-1:0]  mac_out,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ACC_W-1:0]  r_acc;
    logic [LEN_W-1:0]  r_count;
    logic [ACC_W-1:0]  r_result;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_last;

    // Handshake and status come from registered state only, so in_ready
    // never depends combinationally on in_valid.
    assign in_ready   = (r_state == ST_RUN);
    assign busy       = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign done       = (r_state == ST_DONE);
    assign w_accept   = in_valid & in_ready;
    assign w_start_ok = (r_state == ST_IDLE) & start;
    assign w_last     = w_accept && (r_count == LEN_W'(1));

    // The MAC sits beside this block; its operands are pure wires.
    assign mac_a   = a_in;
    assign mac_b   = b_in;
    assign mac_acc = r_acc;
    assign result  = r_result;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is honoured only in IDLE.
    always_comb begin
        // NOTE: default first, so no path through the case leaves w_next
        // unassigned (which would infer a latch).
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Accumulator, element counter and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else if (w_start_ok) begin
            r_acc   <= '0;
            r_count <= len;
            // A zero-length job goes straight to DONE with an empty sum.
            if (len == '0) begin
                r_result <= '0;
            end
        end else if (w_accept) begin
            r_acc   <= mac_out;
            r_count <= r_count - LEN_W'(1);
            // result is loaded on the transition into DONE, so it is
            // valid in the same cycle as the done pulse.
            if (w_last) begin
                r_result <= mac_out;
            end
        end
    end

`ifdef MAC_SEQ_OVF_EN
    logic r_ovf;

    // Sticky wrap flag. The product never exceeds 2^ACC_W-1, so a new sum
    // below the old one means the accumulator wrapped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_start_ok) begin
            r_ovf <= 1'b0;
        end else if (w_accept && (mac_out < r_acc)) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer that drives the combinational MAC unit (8x8 multiply plus 16-bit accumulate) through an N-element dot product.
- Accepts a stream of (a, b) operand pairs over a valid/ready handshake and holds the running sum in a register.
- Feeds that register back as the MAC's acc input, then reports the final sum with a one-cycle done pulse.
- The MAC unit is instantiated outside this block, next to it; this block only presents its operands and samples mac_out.

Parameters:
- DATA_W, 8, operand width; must match the MAC a/b inputs.
- ACC_W, 16, accumulator width; must match the MAC acc/mac_out.
- LEN_W, 5, width of the length field; maximum vector length is 2^LEN_W-1 (31).

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a new dot product; sampled only in IDLE.
- len  in  LEN_W  number of pairs to accumulate; sampled with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- a_in  in  DATA_W  operand a.
- b_in  in  DATA_W  operand b.
- mac_a  out  DATA_W  to MAC a; equals a_in.
- mac_b  out  DATA_W  to MAC b; equals b_in.
- mac_acc  out  ACC_W  to MAC acc; equals acc_reg.
- mac_out  in  ACC_W  from MAC.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  ACC_W  final sum; held until the next accepted start.
- ovf  out  1  sticky wrap flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, acc_reg=0, count=0, result=0, done=0, ovf=0.
  - Applies from any state; an operation in progress is abandoned with no done pulse.
- Handshake: accept = in_valid & in_ready.
  - in_ready=1 only in RUN, and it is driven from registered state only.
  - in_ready never depends combinationally on in_valid.
- mac_a, mac_b and mac_acc are pure wires: a_in, b_in and acc_reg respectively.
- FSM states:
  - IDLE:
    - start=1 and len!=0 -> RUN; load count=len, acc_reg=0, ovf=0.
    - start=1 and len==0 -> DONE; acc_reg=0, ovf=0.
    - start=0 -> stay in IDLE.
  - RUN:
    - On accept: acc_reg <= mac_out and count <= count-1.
    - Accept while count==1 -> DONE.
    - No accept -> hold everything, stay in RUN. Gaps in in_valid are allowed without limit.
  - DONE (exactly one cycle):
    - done=1 and result=acc_reg, both visible in this cycle.
    - Then go to IDLE. result is a register loaded on the transition into DONE.
- Latency:
  - Start at edge T -> in_ready=1 in cycle T+1.
  - Last accept at edge K -> done=1 in cycle K+1.
  - With no stalls, done arrives len+1 cycles after start.
- start is ignored while busy=1, including in DONE. No queuing.
- Arithmetic:
  - The sum wraps modulo 2^ACC_W; mac_out is used as-is.
  - Unsigned only.
- Pairs presented with in_valid while not in RUN are not consumed (in_ready=0).

Optional Feature:
- Macro MAC_SEQ_OVF_EN.
- Defined:
  - On each accept, if mac_out < acc_reg (unsigned), set ovf=1. This is a valid wrap test because the product is at most 65025, which is below 2^16.
  - ovf is sticky until the next accepted start or reset.
  - ovf is valid alongside done.
- Undefined: ovf is tied to 0 and no compare logic is present.

Test Plan:
- len=4; pairs (5,10), (15,3), (255,1), (100,2) with in_valid held high -> result=550, done is one cycle wide, 5 cycles after start, ovf=0.
- len=0 with start -> done in the next cycle, result=0, in_ready stays 0 throughout.
- len=3; pairs (2,3), (4,5), (6,7), with in_valid deasserted for 2 cycles between each -> result=68; acc_reg holds during gaps; done follows the third accept by one cycle.
- len=2; pairs (255,255) twice -> result=64514 (130050 mod 65536); ovf=1 with MAC_SEQ_OVF_EN defined, ovf=0 without it.
- Pulse start with len=7 while in RUN from an earlier len=2 job -> the second start is ignored; result is the 2-pair sum; busy falls after the single done.
- rst_n=0 for one cycle after 2 of 4 pairs -> IDLE, result=0, no done pulse; a new len=1 job with pair (9,9) -> result=81.
